// File: rtl/signed_addsub_bcd_seq_pkg.sv
// Shared definitions for the signed add/subtract + BCD conversion unit:
// FSM state encoding and the digit-count helper used by the legality check.
package signed_addsub_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Decimal digits needed for the largest magnitude a WIDTH-bit add/sub
    // can produce, which is 2^width (e.g. -2^(w-1) + -2^(w-1)).
    function automatic int bcd_digits_for(input int width);
        int v;
        int d;
        v = 1 << width;
        d = 0;
        while (v > 0) begin
            v = v / 10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/signed_addsub_bcd_seq_dabble_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module signed_addsub_bcd_seq_dabble_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3-if-at-least-5 correction applied before each shift.
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/signed_addsub_bcd_seq.sv
// Signed add/subtract at full WIDTH+1 precision, followed by a sequential
// shift-add-3 binary-to-BCD conversion of the magnitude (one bit per cycle).
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE. An output transfer
// happens on a rising edge where out_valid and out_ready are both high; while
// out_valid is high and out_ready is low, sum/bcd_sign/bcd_digits are held.
module signed_addsub_bcd_seq
    import signed_addsub_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH:0]        sum,
    output logic                  bcd_sign,
    output logic [4*DIGITS-1:0]   bcd_digits,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int BW = 4 * DIGITS;

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("signed_addsub_bcd_seq: WIDTH must be in 2..16");
    end
    if (DIGITS < bcd_digits_for(WIDTH)) begin : g_bad_digits
        $error("signed_addsub_bcd_seq: DIGITS too small for WIDTH");
    end

    state_t            state_q, state_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic [WIDTH:0]    mag_q, mag_d;
    logic [BW-1:0]     shift_q, shift_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic [BW-1:0]     shift_adj;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    logic [WIDTH:0]    a_ext, b_ext, res;
    logic [BW+WIDTH:0] shifted;

    assign a_ext   = {a[WIDTH-1], a};
    assign b_ext   = {b[WIDTH-1], b};
    assign res     = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    assign shifted = {shift_adj, mag_q} << 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        signed_addsub_bcd_seq_dabble_digit_adj u_adj (
            .din  (shift_q[4*g +: 4]),
            .dout (shift_adj[4*g +: 4])
        );
    end

    // Next-state and next-output computation for the IDLE/CONV/DONE sequence.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        mag_d       = mag_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        in_ready_d  = in_ready_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    sum_d      = res;
                    sign_d     = res[WIDTH];
                    mag_d      = res[WIDTH] ? -res : res;
                    shift_d    = '0;
                    cnt_d      = CW'(WIDTH + 1);
                    busy_d     = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d = shifted[BW+WIDTH:WIDTH+1];
                mag_d   = shifted[WIDTH:0];
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d       = shifted[BW+WIDTH:WIDTH+1];
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sum_q       <= '0;
            mag_q       <= '0;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            mag_q       <= mag_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign sum        = sum_q;
    assign bcd_sign   = sign_q;
    assign bcd_digits = bcd_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_signed_addsub_bcd_seq.sv
// Bench for signed_addsub_bcd_seq: one WIDTH=4/DIGITS=2 instance and one
// WIDTH=8/DIGITS=3 instance. Drivers push expected results into queues; a
// monitor per instance pops and compares on each output transfer.
module tb_signed_addsub_bcd_seq;
    import signed_addsub_bcd_seq_pkg::*;

    typedef struct {
        int sum;
        bit sign;
        int digits;
        int acc;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- DUT (WIDTH=4) ----------------
    logic       in_valid4 = 1'b0;
    logic       in_ready4;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       sub4 = 1'b0;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;
    logic [4:0] sum4;
    logic       sign4;
    logic [7:0] digits4;
    logic       busy4;
    logic [1:0] state4;

    signed_addsub_bcd_seq #(.WIDTH(4), .DIGITS(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .sub(sub4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .bcd_sign(sign4), .bcd_digits(digits4), .busy(busy4),
        .dbg_state(state4)
    );

    // ---------------- DUT (WIDTH=8) ----------------
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sub8 = 1'b0;
    logic        out_valid8;
    logic        out_ready8 = 1'b0;
    logic [8:0]  sum8;
    logic        sign8;
    logic [11:0] digits8;
    logic        busy8;
    logic [1:0]  state8;

    signed_addsub_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .bcd_sign(sign8), .bcd_digits(digits8), .busy(busy8),
        .dbg_state(state8)
    );

    // ---------------- reference model and checker ----------------
    function automatic exp_t model(input int w, input int a, input int b, input bit s);
        exp_t e;
        int   r;
        int   m;
        r        = s ? (a - b) : (a + b);
        e.sum    = r & ((1 << (w + 1)) - 1);
        e.sign   = (r < 0);
        m        = (r < 0) ? -r : r;
        e.digits = (m % 10) + 16 * ((m / 10) % 10) + 256 * ((m / 100) % 10);
        e.acc    = 0;
        return e;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- scoreboards ----------------
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4;
    exp_t e8;
    logic prev_ov4 = 1'b0;
    logic prev_ov8 = 1'b0;
    logic rr4 = 1'b0, fr4 = 1'b1;
    logic rr8 = 1'b0, fr8 = 1'b1;

    // Consumer side: random or forced out_ready per instance.
    always @(posedge clk) begin
        #1;
        out_ready4 = rr4 ? ($urandom_range(0, 3) != 0) : fr4;
        out_ready8 = rr8 ? ($urandom_range(0, 3) != 0) : fr8;
    end

    always @(negedge clk) begin : mon4
        if (rst) begin
            q4.delete();
            prev_ov4 = 1'b0;
        end else begin
            if (out_valid4 || busy4) check("in_ready_low_4", int'(in_ready4), 0);
            if (out_valid4 && !prev_ov4) begin
                check("pending_at_valid_4", int'(q4.size() != 0), 1);
                if (q4.size() != 0) check("latency_4", cyc - q4[0].acc, 5);
            end
            if (out_valid4 && out_ready4) begin
                check("pending_at_pop_4", int'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    e4 = q4.pop_front();
                    check("sum_4", int'(sum4), e4.sum);
                    check("sign_4", int'(sign4), int'(e4.sign));
                    check("digits_4", int'(digits4), e4.digits);
                end
            end
            prev_ov4 = out_valid4;
        end
    end

    always @(negedge clk) begin : mon8
        if (rst) begin
            q8.delete();
            prev_ov8 = 1'b0;
        end else begin
            if (out_valid8 || busy8) check("in_ready_low_8", int'(in_ready8), 0);
            if (out_valid8 && !prev_ov8) begin
                check("pending_at_valid_8", int'(q8.size() != 0), 1);
                if (q8.size() != 0) check("latency_8", cyc - q8[0].acc, 9);
            end
            if (out_valid8 && out_ready8) begin
                check("pending_at_pop_8", int'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    check("sum_8", int'(sum8), e8.sum);
                    check("sign_8", int'(sign8), int'(e8.sign));
                    check("digits_8", int'(digits8), e8.digits);
                end
            end
            prev_ov8 = out_valid8;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int inst, input int a, input int b, input bit s);
        exp_t e;
        int   n;
        e = model((inst == 4) ? 4 : 8, a, b, s);
        @(negedge clk);
        if (inst == 4) begin
            a4 = 4'(a); b4 = 4'(b); sub4 = s; in_valid4 = 1'b1;
        end else begin
            a8 = 8'(a); b8 = 8'(b); sub8 = s; in_valid8 = 1'b1;
        end
        n = 0;
        while (!((inst == 4) ? in_ready4 : in_ready8) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", int'(n < 500), 1);
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (inst == 4) begin
            q4.push_back(e);
            in_valid4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
        end else begin
            q8.push_back(e);
            in_valid8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
        end
    endtask

    task automatic drain(input int inst);
        int n;
        n = 0;
        while (n < 3000 && ((inst == 4) ? (q4.size() != 0 || out_valid4)
                                        : (q8.size() != 0 || out_valid8))) begin
            @(negedge clk);
            n++;
        end
        check((inst == 4) ? "drain_4" : "drain_8", int'(n < 3000), 1);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid_4", int'(out_valid4), 0);
        check("rst_busy_4", int'(busy4), 0);
        check("rst_in_ready_4", int'(in_ready4), 1);
        check("rst_sum_4", int'(sum4), 0);
        check("rst_sign_4", int'(sign4), 0);
        check("rst_digits_4", int'(digits4), 0);
        check("rst_state_4", int'(state4), int'(ST_IDLE));
        check("rst_out_valid_8", int'(out_valid8), 0);
        check("rst_in_ready_8", int'(in_ready8), 1);
        check("rst_sum_8", int'(sum8), 0);
        check("rst_state_8", int'(state8), int'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        exp_t e;
        int   n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // Directed WIDTH=4 cases, including both extremes.
        issue(4, 7, 7, 1'b0);
        issue(4, -8, -8, 1'b0);
        issue(4, 3, 5, 1'b1);
        issue(4, -8, 7, 1'b1);
        issue(4, 5, 5, 1'b1);
        issue(4, 0, -8, 1'b1);
        drain(4);

        // Back-pressure in DONE with in_valid pulsing on new operands.
        fr4 = 1'b0;
        @(posedge clk);
        issue(4, -3, 6, 1'b1);
        e = model(4, -3, 6, 1'b1);
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_reached_4", int'(out_valid4), 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid4 = i[0];
            a4 = 4'($urandom); b4 = 4'($urandom); sub4 = 1'($urandom);
            @(negedge clk);
            check("hold_in_ready", int'(in_ready4), 0);
            check("hold_out_valid", int'(out_valid4), 1);
            check("hold_sum", int'(sum4), e.sum);
            check("hold_sign", int'(sign4), int'(e.sign));
            check("hold_digits", int'(digits4), e.digits);
        end
        in_valid4 = 1'b0;
        fr4 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_in_ready", int'(in_ready4), 1);
        check("release_out_valid", int'(out_valid4), 0);
        repeat (3) begin
            @(negedge clk);
            check("no_accept_busy", int'(busy4), 0);
            check("no_accept_valid", int'(out_valid4), 0);
        end

        // Reset pulse during conversion, sampled while two shifts remain.
        issue(4, 6, -7, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        issue(4, -6, 7, 1'b1);
        drain(4);

        // Randomised WIDTH=4 traffic with random consumer stalls.
        rr4 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(4, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain(4);
        rr4 = 1'b0;

        // WIDTH=8 extremes and random sweep.
        issue(8, -128, -128, 1'b0);
        issue(8, 127, -128, 1'b1);
        issue(8, -128, 127, 1'b1);
        issue(8, 0, 0, 1'b0);
        issue(8, -1, 1, 1'b0);
        issue(8, 99, 1, 1'b0);
        drain(8);
        rr8 = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            issue(8, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 1)) @(posedge clk);
        end
        drain(8);
        rr8 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
